fisc_run_ctrl: RTL and testbench
================================

FISC_RUN_CTRL -- requirements
Module: fisc_run_ctrl

Interface
REQ-001 Parameter AddressSize, default 16, width of PC and breakpoint address.
REQ-002 Parameter ResetCycles, default 9, clock cycles the CPU reset is held asserted.
REQ-003 Parameter HaltAddr, default 16'hFFFF, PC value that terminates a run.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 PCval  input  AddressSize  current CPU program counter.
REQ-007 run_req  input  1  one-cycle pulse: start/resume free running.
REQ-008 step_req  input  1  one-cycle pulse: execute exactly one CPU cycle.
REQ-009 stop_req  input  1  one-cycle pulse: pause a run.
REQ-010 restart_req  input  1  one-cycle pulse: re-reset the CPU from HALT.
REQ-011 bp_en  input  1  breakpoint enable.
REQ-012 bp_addr  input  AddressSize  breakpoint PC value.
REQ-013 cpu_rst_n  output  1  active-low CPU reset.
REQ-014 cpu_clk_en  output  1  CPU clock enable.
REQ-015 state  output  3  current state encoding.
REQ-016 halted  output  1  high while in HALT.
REQ-017 halt_cause  output  2  00 none, 01 HaltAddr reached, 10 breakpoint.
REQ-018 cycle_count  output  32  count of enabled CPU cycles since last HOLD exit.

Function
REQ-019 States SHALL be HOLD=0, IDLE=1, RUN=2, STEP=3, HALT=4; other encodings SHALL go to HOLD next cycle.
REQ-020 HOLD: cpu_rst_n=0, cpu_clk_en=1, hold counter increments; after ResetCycles cycles in HOLD -> IDLE, counter cleared.
REQ-021 IDLE: cpu_rst_n=1, cpu_clk_en=0; run_req -> RUN; else step_req -> STEP; run_req wins if both high.
REQ-022 RUN: cpu_clk_en=1 unless a stop condition holds this cycle.
REQ-023 Stop condition: pc_hit = (PCval==HaltAddr); bp_hit = bp_en & (PCval==bp_addr) & not first RUN cycle.
REQ-024 cpu_clk_en SHALL be combinational from state and compares, so CPU does not advance on the edge a hit is seen.
REQ-025 RUN with pc_hit -> HALT, halt_cause=01; pc_hit takes priority over bp_hit.
REQ-026 RUN with bp_hit only -> IDLE, halt_cause=10; run_req later resumes past the breakpoint (first-cycle suppression, REQ-023).
REQ-027 RUN with stop_req and no hit -> IDLE, halt_cause unchanged; a hit in the same cycle overrides stop_req.
REQ-028 STEP: cpu_clk_en=1 for exactly one cycle, then -> IDLE; pc_hit during STEP -> HALT with cpu_clk_en=0.
REQ-029 HALT: cpu_clk_en=0, halted=1; only restart_req is accepted -> HOLD; run_req/step_req/stop_req ignored.
REQ-030 halt_cause SHALL clear to 00 on entry to RUN or STEP.
REQ-031 cycle_count SHALL increment on each edge with cpu_clk_en=1 outside HOLD, saturate at 32'hFFFFFFFF, clear on HOLD exit.
REQ-032 Request pulses arriving in states that do not accept them SHALL be dropped, not queued.
REQ-033 All outputs except cpu_clk_en SHALL be registered.

Reset
REQ-034 reset=1 on a rising edge: state=HOLD, hold counter=0, cycle_count=0, halt_cause=00, halted=0, cpu_rst_n=0, cpu_clk_en=1 the following cycle.
REQ-035 reset asserted in any state, including mid-RUN or mid-HOLD, SHALL restart the full ResetCycles sequence.

Verification
REQ-036 Release reset, no requests -> cpu_rst_n low exactly 9 cycles, then IDLE, cpu_clk_en=0, cycle_count=0.
REQ-037 IDLE, run_req, PCval ramps 0,1,2,...,FFFF -> cpu_clk_en drops in the cycle PCval=FFFF, state=HALT, halt_cause=01, cycle_count=16'hFFFF.
REQ-038 bp_en=1, bp_addr=0010, run -> stop at PCval=0010 in IDLE, halt_cause=10; run_req again -> PC advances to 0011 without re-trigger.
REQ-039 IDLE, run_req and step_req same cycle -> RUN; later step_req alone -> exactly one enabled cycle then IDLE.
REQ-040 bp_addr=FFFF, bp_en=1, PC reaches FFFF -> HALT, halt_cause=01; stop_req same cycle ignored.
REQ-041 HALT, run_req -> no change; restart_req -> HOLD, 9 reset cycles, IDLE, cycle_count=0; reset mid-RUN -> HOLD next cycle.

Source files
------------

// File: rtl/fisc_run_ctrl_if.sv
// Debug run-control bus between the front panel / debugger and fisc_run_ctrl.
// master drives requests and breakpoint setup; slave (the controller) drives CPU control and status.
interface fisc_run_ctrl_if #(
  parameter int AddressSize = 16
) ();
  logic [AddressSize-1:0] PCval;
  logic                   run_req;
  logic                   step_req;
  logic                   stop_req;
  logic                   restart_req;
  logic                   bp_en;
  logic [AddressSize-1:0] bp_addr;
  logic                   cpu_rst_n;
  logic                   cpu_clk_en;
  logic [2:0]             state;
  logic                   halted;
  logic [1:0]             halt_cause;
  logic [31:0]            cycle_count;

  modport master (
    output PCval, run_req, step_req, stop_req, restart_req, bp_en, bp_addr,
    input  cpu_rst_n, cpu_clk_en, state, halted, halt_cause, cycle_count
  );

  modport slave (
    input  PCval, run_req, step_req, stop_req, restart_req, bp_en, bp_addr,
    output cpu_rst_n, cpu_clk_en, state, halted, halt_cause, cycle_count
  );
endinterface

// File: rtl/fisc_run_ctrl.sv
// Run controller for the FISC CPU: reset sequencing, run/step/stop, breakpoint and halt-address
// detection. The CPU clock enable is combinational so a hit stops the CPU on the very edge it is seen.
module fisc_run_ctrl #(
  parameter int                     AddressSize = 16,
  parameter int                     ResetCycles = 9,
  parameter logic [AddressSize-1:0] HaltAddr    = 16'hFFFF
) (
  input  logic           clk,
  input  logic           reset,
  fisc_run_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_HOLD = 3'd0,
    S_IDLE = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_HALT = 3'd4
  } state_e;

  localparam int          HcW    = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;
  localparam logic [1:0]  C_NONE = 2'b00;
  localparam logic [1:0]  C_PC   = 2'b01;
  localparam logic [1:0]  C_BP   = 2'b10;

  state_e           state_q, state_d;
  logic [HcW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [1:0]       cause_q, cause_d;
  logic             rst_n_q, rst_n_d;
  logic             halted_q, halted_d;
  logic             first_q, first_d;
  logic             pc_hit, bp_hit, clk_en;

  // first_q marks the first RUN cycle so a resume from a breakpoint steps past it
  assign pc_hit = (bus.PCval == HaltAddr);
  assign bp_hit = bus.bp_en && (bus.PCval == bus.bp_addr) && !first_q;

  always_comb begin
    clk_en = 1'b0;
    case (state_q)
      S_HOLD:  clk_en = 1'b1;
      S_RUN:   clk_en = !(pc_hit || bp_hit);
      S_STEP:  clk_en = !pc_hit;
      default: clk_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cyc_d      = cyc_q;
    cause_d    = cause_q;
    first_d    = 1'b0;
    if (clk_en && state_q != S_HOLD && cyc_q != 32'hFFFF_FFFF)
      cyc_d = cyc_q + 32'd1;
    case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HcW'(ResetCycles - 1)) begin
          state_d    = S_IDLE;
          hold_cnt_d = '0;
          cyc_d      = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.run_req) begin
          state_d = S_RUN;
          cause_d = C_NONE;
          first_d = 1'b1;
        end else if (bus.step_req) begin
          state_d = S_STEP;
          cause_d = C_NONE;
        end
      end
      S_RUN: begin
        if (pc_hit) begin
          state_d = S_HALT;
          cause_d = C_PC;
        end else if (bp_hit) begin
          state_d = S_IDLE;
          cause_d = C_BP;
        end else if (bus.stop_req) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (pc_hit) begin
          state_d = S_HALT;
          cause_d = C_PC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: begin
        if (bus.restart_req) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_HOLD;
        hold_cnt_d = '0;
      end
    endcase
    rst_n_d  = (state_d != S_HOLD);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_HOLD;
      hold_cnt_q <= '0;
      cyc_q      <= '0;
      cause_q    <= C_NONE;
      rst_n_q    <= 1'b0;
      halted_q   <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      cyc_q      <= cyc_d;
      cause_q    <= cause_d;
      rst_n_q    <= rst_n_d;
      halted_q   <= halted_d;
      first_q    <= first_d;
    end
  end

  assign bus.cpu_rst_n   = rst_n_q;
  assign bus.cpu_clk_en  = clk_en;
  assign bus.state       = state_q;
  assign bus.halted      = halted_q;
  assign bus.halt_cause  = cause_q;
  assign bus.cycle_count = cyc_q;
endmodule

// File: tb/tb_fisc_run_ctrl.sv
// Bench for fisc_run_ctrl: vector table, directed corner sequences, and randomized run
// against a reference model of the run-control rules.
module tb_fisc_run_ctrl;
  localparam int M_HOLD = 0, M_IDLE = 1, M_RUN = 2, M_STEP = 3, M_HALT = 4;
  localparam int RCYC = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fisc_run_ctrl_if #(.AddressSize(16)) bus ();

  fisc_run_ctrl #(.AddressSize(16), .ResetCycles(RCYC), .HaltAddr(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic        auto_pc;
  logic [15:0] pc;

  typedef struct {
    logic        run, step, stop, restart, bpe;
    logic [15:0] bpa, pc;
    logic        en;
    logic [2:0]  st;
    logic        rstn, hlt;
    logic [1:0]  cause;
    logic [31:0] cnt;
  } vec_t;
  vec_t vt[18];

  // reference model state
  int      m_st, m_hold, m_cause;
  longint  m_cnt;
  bit      m_fresh;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int r, int s, int sp, int rs, int be, int ba, int p,
                              int en, int st, int rn, int h, int c, int n);
    vec_t v;
    v.run = 1'(r); v.step = 1'(s); v.stop = 1'(sp); v.restart = 1'(rs); v.bpe = 1'(be);
    v.bpa = 16'(ba); v.pc = 16'(p); v.en = 1'(en); v.st = 3'(st); v.rstn = 1'(rn);
    v.hlt = 1'(h); v.cause = 2'(c); v.cnt = 32'(n);
    return v;
  endfunction

  task automatic clr_req();
    bus.run_req = 0; bus.step_req = 0; bus.stop_req = 0; bus.restart_req = 0;
  endtask

  // one clock; optional CPU model advances PC on enabled edges, holds it at 0 in reset
  task automatic step_clk();
    logic en_s; logic [2:0] st_s;
    @(negedge clk);
    en_s = bus.cpu_clk_en; st_s = bus.state;
    @(posedge clk); #1;
    if (auto_pc) begin
      if (st_s == 3'd0) pc = 16'h0;
      else if (en_s) pc = pc + 16'h1;
      bus.PCval = pc;
    end
    #1;
  endtask

  task automatic hold_len(input string nm);
    int n;
    n = 0;
    while (bus.cpu_rst_n !== 1'b1 && n < 40) begin step_clk(); n++; end
    chk(nm, 64'(n), 64'(RCYC));
    chk({nm, "_idle"}, {bus.state, bus.cpu_clk_en, bus.cycle_count}, {3'd1, 1'b0, 32'd0});
  endtask

  function automatic logic m_en(int st, logic pch, logic bph);
    case (st)
      M_HOLD:  return 1'b1;
      M_RUN:   return !(pch || bph);
      M_STEP:  return !pch;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_st = M_HOLD; m_hold = 0; m_cnt = 0; m_cause = 0; m_fresh = 0;
  endtask

  // advances the model over one edge given the inputs that were applied in that cycle
  task automatic m_edge(logic rst, logic run, logic stp, logic stop, logic rs,
                        logic pch, logic bph_raw);
    logic bph, en;
    int   nst;
    bit   nfresh;
    if (rst) begin m_reset(); return; end
    bph    = bph_raw && !m_fresh;
    en     = m_en(m_st, pch, bph);
    nst    = m_st;
    nfresh = 0;
    if (en && m_st != M_HOLD && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    if (m_st == M_HOLD) begin
      m_hold++;
      if (m_hold == RCYC) begin nst = M_IDLE; m_hold = 0; m_cnt = 0; end
    end else if (m_st == M_IDLE) begin
      if (run) begin nst = M_RUN; m_cause = 0; nfresh = 1; end
      else if (stp) begin nst = M_STEP; m_cause = 0; end
    end else if (m_st == M_RUN) begin
      if (pch) begin nst = M_HALT; m_cause = 1; end
      else if (bph) begin nst = M_IDLE; m_cause = 2; end
      else if (stop) nst = M_IDLE;
    end else if (m_st == M_STEP) begin
      nst = pch ? M_HALT : M_IDLE;
      if (pch) m_cause = 1;
    end else if (m_st == M_HALT) begin
      if (rs) begin nst = M_HOLD; m_hold = 0; end
    end
    m_st = nst; m_fresh = nfresh;
  endtask

  initial begin
    int          n;
    logic [16:0] drop_pc;
    logic        r_rst, pch, bph, exp_en;

    vt[0]  = mk(0,0,0,0,0,'h40,'h5,     0, M_IDLE,1,0,0,0);
    vt[1]  = mk(0,0,1,0,0,'h40,'h5,     0, M_IDLE,1,0,0,0);
    vt[2]  = mk(0,1,0,0,0,'h40,'h5,     0, M_STEP,1,0,0,0);
    vt[3]  = mk(1,0,0,0,0,'h40,'h5,     1, M_IDLE,1,0,0,1);
    vt[4]  = mk(1,1,0,0,0,'h40,'h6,     0, M_RUN, 1,0,0,1);
    vt[5]  = mk(0,1,0,0,0,'h40,'h6,     1, M_RUN, 1,0,0,2);
    vt[6]  = mk(0,0,1,0,0,'h40,'h7,     1, M_IDLE,1,0,0,3);
    vt[7]  = mk(1,0,0,0,1,'h8, 'h8,     0, M_RUN, 1,0,0,3);
    vt[8]  = mk(0,0,0,0,1,'h8, 'h8,     1, M_RUN, 1,0,0,4);
    vt[9]  = mk(0,0,0,0,1,'h9, 'h9,     0, M_IDLE,1,0,2,4);
    vt[10] = mk(0,1,0,0,1,'h9, 'h9,     0, M_STEP,1,0,0,4);
    vt[11] = mk(0,0,0,0,0,'h9, 'h9,     1, M_IDLE,1,0,0,5);
    vt[12] = mk(1,0,0,0,0,'h9, 'hA,     0, M_RUN, 1,0,0,5);
    vt[13] = mk(0,0,1,0,1,'hFFFF,'hFFFF,0, M_HALT,1,1,1,5);
    vt[14] = mk(1,0,0,0,0,'h0, 'h0,     0, M_HALT,1,1,1,5);
    vt[15] = mk(0,1,0,0,0,'h0, 'h0,     0, M_HALT,1,1,1,5);
    vt[16] = mk(0,0,1,0,0,'h0, 'h0,     0, M_HALT,1,1,1,5);
    vt[17] = mk(0,0,0,1,0,'h0, 'h0,     0, M_HOLD,0,0,1,5);

    auto_pc = 0; pc = 0; reset = 1;
    clr_req(); bus.bp_en = 0; bus.bp_addr = 16'h0040; bus.PCval = 16'h0;

    // reset state and release sequence
    repeat (3) step_clk();
    chk("rst_state", {bus.state, bus.cpu_rst_n, bus.halted, bus.halt_cause}, {3'd0, 1'b0, 1'b0, 2'd0});
    chk("rst_cnt", 64'(bus.cycle_count), 64'd0);
    chk("rst_en", 64'(bus.cpu_clk_en), 64'd1);
    reset = 0;
    hold_len("hold_after_reset");

    // vector table, starting from IDLE with cycle_count 0
    for (int i = 0; i < 18; i++) begin
      bus.run_req = vt[i].run; bus.step_req = vt[i].step; bus.stop_req = vt[i].stop;
      bus.restart_req = vt[i].restart; bus.bp_en = vt[i].bpe; bus.bp_addr = vt[i].bpa;
      bus.PCval = vt[i].pc;
      @(negedge clk);
      chk($sformatf("vec%0d_en", i), 64'(bus.cpu_clk_en), 64'(vt[i].en));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out", i),
          {bus.state, bus.cpu_rst_n, bus.halted, bus.halt_cause, bus.cycle_count},
          {vt[i].st, vt[i].rstn, vt[i].hlt, vt[i].cause, vt[i].cnt});
      clr_req(); #1;
    end
    bus.bp_en = 0;
    hold_len("hold_after_restart");

    // STEP onto the halt address: no enabled cycle, HALT with cause 01
    bus.PCval = 16'hFFFF; bus.step_req = 1; step_clk(); clr_req();
    chk("step_pchit_en", 64'(bus.cpu_clk_en), 64'd0);
    step_clk();
    chk("step_pchit_halt", {bus.state, bus.halted, bus.halt_cause, bus.cycle_count},
        {3'd4, 1'b1, 2'd1, 32'd0});

    // reset in the middle of HOLD restarts the full sequence
    bus.restart_req = 1; step_clk(); clr_req();
    repeat (4) step_clk();
    reset = 1; step_clk(); reset = 0;
    chk("midhold_rst", {bus.state, bus.cpu_rst_n, bus.halt_cause}, {3'd0, 1'b0, 2'd0});
    hold_len("hold_after_midhold_rst");

    // reset in the middle of RUN
    bus.PCval = 16'h0100; bus.run_req = 1; step_clk(); clr_req();
    repeat (3) step_clk();
    chk("midrun_state", 64'(bus.state), 64'd2);
    reset = 1; step_clk(); reset = 0;
    chk("midrun_rst", {bus.state, bus.cpu_rst_n, bus.cycle_count}, {3'd0, 1'b0, 32'd0});
    hold_len("hold_after_midrun_rst");

    // breakpoint at 0x0010, then resume past it
    auto_pc = 1; pc = 0; bus.PCval = 0; bus.bp_en = 1; bus.bp_addr = 16'h0010;
    bus.run_req = 1; step_clk(); clr_req();
    n = 0;
    while (bus.state == 3'd2 && n < 100) begin step_clk(); n++; end
    chk("bp_stop", {bus.state, bus.halt_cause, bus.PCval, bus.cycle_count},
        {3'd1, 2'd2, 16'h0010, 32'd16});
    bus.run_req = 1; step_clk(); clr_req();
    step_clk();
    chk("bp_resume", {bus.state, bus.halt_cause, bus.PCval}, {3'd2, 2'd0, 16'h0011});
    bus.stop_req = 1; step_clk(); clr_req();
    chk("bp_stopreq", {bus.state, bus.cycle_count}, {3'd1, 32'd18});
    bus.bp_en = 0;

    // full PC ramp to the halt address from a fresh reset
    reset = 1; step_clk(); reset = 0;
    hold_len("hold_before_ramp");
    bus.run_req = 1; step_clk(); clr_req();
    drop_pc = 17'h1_0000; n = 0;
    while (bus.state == 3'd2 && n < 70000) begin
      if (!bus.cpu_clk_en && drop_pc[16]) drop_pc = {1'b0, bus.PCval};
      step_clk(); n++;
    end
    chk("ramp_drop_pc", 64'(drop_pc), 64'h0FFFF);
    chk("ramp_halt", {bus.state, bus.halted, bus.halt_cause, bus.cycle_count},
        {3'd4, 1'b1, 2'd1, 32'h0000_FFFF});
    bus.run_req = 1; step_clk(); clr_req();
    chk("halt_ignores_run", {bus.state, bus.cpu_clk_en}, {3'd4, 1'b0});
    bus.restart_req = 1; step_clk(); clr_req();
    hold_len("hold_after_ramp_restart");
    auto_pc = 0;

    // randomized traffic against the reference model
    reset = 1; step_clk(); reset = 0; m_reset();
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      bus.run_req = ($urandom_range(0, 3) == 0);
      bus.step_req = ($urandom_range(0, 3) == 0);
      bus.stop_req = ($urandom_range(0, 4) == 0);
      bus.restart_req = ($urandom_range(0, 5) == 0);
      bus.bp_en = 1'($urandom_range(0, 1));
      bus.bp_addr = 16'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       bus.PCval = 16'hFFFF;
        1, 2:    bus.PCval = bus.bp_addr;
        default: bus.PCval = 16'($urandom_range(0, 15));
      endcase
      reset = r_rst;
      #1;
      pch = (bus.PCval == 16'hFFFF);
      bph = bus.bp_en && (bus.PCval == bus.bp_addr);
      exp_en = m_en(m_st, pch, bph && !m_fresh);
      chk($sformatf("rand%0d", c),
          {bus.cycle_count, bus.state, bus.cpu_rst_n, bus.halted, bus.halt_cause, bus.cpu_clk_en},
          {32'(m_cnt), 3'(m_st), 1'(m_st != M_HOLD), 1'(m_st == M_HALT), 2'(m_cause), exp_en});
      m_edge(r_rst, bus.run_req, bus.step_req, bus.stop_req, bus.restart_req, pch, bph);
      step_clk();
    end
    reset = 0; clr_req();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
